// File: rtl/regfile_pkg.sv
// Shared register-file writeback definitions: datapath widths, requester ids
// and the registered write-port record.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

  // x0 is hardwired to zero, so writes to it are accepted but dropped.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/wb_arb2.sv
// Two-requester writeback grant logic. Round-robin by default; fixed load
// priority with ALU anti-starvation when REGFILE_WB_FIXED_PRIO_EN is defined.
module wb_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
`ifdef REGFILE_WB_FIXED_PRIO_EN
  input  logic [1:0] starve_cnt,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01: grant[REQ_ALU]  = 1'b1;
      2'b10: grant[REQ_LOAD] = 1'b1;
      2'b11: begin
`ifdef REGFILE_WB_FIXED_PRIO_EN
        // Load wins ties unless the ALU has already lost three in a row.
        if (starve_cnt == 2'd3) grant[REQ_ALU] = 1'b1;
        else                    grant[REQ_LOAD] = 1'b1;
`else
        if (last_grant == REQ_ALU) grant[REQ_LOAD] = 1'b1;
        else                       grant[REQ_ALU]  = 1'b1;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto a single register-file write
// port, one write per cycle. Optional mode: REGFILE_WB_FIXED_PRIO_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb0_valid_i,
  input  logic [REG_ADDR_W-1:0] wb0_addr_i,
  input  logic [XLEN-1:0]       wb0_data_i,
  output logic                  wb0_ready_o,
  input  logic                  wb1_valid_i,
  input  logic [REG_ADDR_W-1:0] wb1_addr_i,
  input  logic [XLEN-1:0]       wb1_data_i,
  output logic                  wb1_ready_o,
  input  logic                  flush_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_addr_o,
  output logic [XLEN-1:0]       rf_data_o,
  output logic                  last_grant_o
);

  logic [1:0]            grant;
  logic [1:0]            acc_p0;
  logic                  vld_p0;
  logic [REG_ADDR_W-1:0] addr_p0;
  logic [XLEN-1:0]       data_p0;
  rf_wr_t                wr_p1;
  logic                  last_grant_q;

`ifdef REGFILE_WB_FIXED_PRIO_EN
  logic [1:0] starve_cnt_q;
`endif

  wb_arb2 u_arb (
    .valid      ({wb1_valid_i, wb0_valid_i}),
    .last_grant (last_grant_q),
`ifdef REGFILE_WB_FIXED_PRIO_EN
    .starve_cnt (starve_cnt_q),
`endif
    .grant      (grant)
  );

  // Stage p0: accept decision and operand select
  always_comb begin
    acc_p0  = flush_i ? 2'b00 : grant;
    vld_p0  = |acc_p0;
    addr_p0 = acc_p0[REQ_LOAD] ? wb1_addr_i : wb0_addr_i;
    data_p0 = acc_p0[REQ_LOAD] ? wb1_data_i : wb0_data_i;
  end

  assign wb0_ready_o = acc_p0[REQ_ALU];
  assign wb1_ready_o = acc_p0[REQ_LOAD];

  // Stage p1: registered write port; address/data hold when nothing is accepted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_p1        <= '0;
      last_grant_q <= REQ_LOAD;
    end else begin
      wr_p1.we <= vld_p0 && !is_x0(addr_p0);
      if (vld_p0) begin
        wr_p1.addr   <= addr_p0;
        wr_p1.data   <= data_p0;
        last_grant_q <= acc_p0[REQ_LOAD];
      end
    end
  end

`ifdef REGFILE_WB_FIXED_PRIO_EN
  // A flushed cycle is not counted as a lost arbitration.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt_q <= 2'd0;
    end else if (!flush_i) begin
      if (wb0_valid_i && !acc_p0[REQ_ALU])
        starve_cnt_q <= (starve_cnt_q == 2'd3) ? 2'd3 : starve_cnt_q + 2'd1;
      else
        starve_cnt_q <= 2'd0;
    end
  end
`endif

  assign rf_we_o      = wr_p1.we;
  assign rf_addr_o    = wr_p1.addr;
  assign rf_data_o    = wr_p1.data;
  assign last_grant_o = last_grant_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus random
// traffic against a queue-based reference model of the arbitration rules.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        wb0_valid_i, wb1_valid_i, flush_i;
  logic [4:0]  wb0_addr_i, wb1_addr_i;
  logic [31:0] wb0_data_i, wb1_data_i;
  logic        wb0_ready_o, wb1_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        last_grant_o;

  regfile_wb_arbiter dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .wb0_valid_i  (wb0_valid_i),
    .wb0_addr_i   (wb0_addr_i),
    .wb0_data_i   (wb0_data_i),
    .wb0_ready_o  (wb0_ready_o),
    .wb1_valid_i  (wb1_valid_i),
    .wb1_addr_i   (wb1_addr_i),
    .wb1_data_i   (wb1_data_i),
    .wb1_ready_o  (wb1_ready_o),
    .flush_i      (flush_i),
    .rf_we_o      (rf_we_o),
    .rf_addr_o    (rf_addr_o),
    .rf_data_o    (rf_data_o),
    .last_grant_o (last_grant_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit        we;
    bit [4:0]  addr;
    bit [31:0] data;
    bit        lg;
  } exp_wr_t;

  exp_wr_t  wr_q[$];
  bit [1:0] rdy_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: who won last, what the port currently holds.
  bit        m_lg     = 1'b1;
  bit [4:0]  m_addr   = '0;
  bit [31:0] m_data   = '0;
  int        m_starve = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: applies one cycle of stimulus and records the
  // expected ready response and the expected write-port state after the edge.
  task automatic drive(input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                       input bit v1, input bit [4:0] a1, input bit [31:0] d1,
                       input bit fl);
    int      win;
    exp_wr_t e;
    wb0_valid_i = v0; wb0_addr_i = a0; wb0_data_i = d0;
    wb1_valid_i = v1; wb1_addr_i = a1; wb1_data_i = d1;
    flush_i     = fl;
    win = -1;
    if (!fl) begin
      if (v0 && v1) begin
`ifdef REGFILE_WB_FIXED_PRIO_EN
        win = (m_starve == 3) ? 0 : 1;
`else
        win = (m_lg == 1'b1) ? 0 : 1;
`endif
      end else if (v0) win = 0;
      else if (v1)     win = 1;
`ifdef REGFILE_WB_FIXED_PRIO_EN
      if (v0 && win != 0) m_starve = (m_starve < 3) ? m_starve + 1 : 3;
      else                m_starve = 0;
`endif
    end
    rdy_q.push_back({win == 1, win == 0});
    e.we = 1'b0;
    if (win >= 0) begin
      m_addr = (win == 1) ? a1 : a0;
      m_data = (win == 1) ? d1 : d0;
      m_lg   = (win == 1);
      e.we   = (m_addr != 0);
    end
    e.addr = m_addr;
    e.data = m_data;
    e.lg   = m_lg;
    wr_q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Ready monitor: readies are combinational, sampled mid-low-phase.
  initial begin
    bit [1:0] r;
    forever begin
      @(negedge clk_i);
      #2;
      if (rdy_q.size() > 0) begin
        r = rdy_q.pop_front();
        check("ready{1,0}", {30'd0, wb1_ready_o, wb0_ready_o}, {30'd0, r});
      end
    end
  end

  // Write-port monitor: sampled just after the rising edge.
  initial begin
    exp_wr_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        check("rf_we",      {31'd0, rf_we_o},      {31'd0, e.we});
        check("rf_addr",    {27'd0, rf_addr_o},    {27'd0, e.addr});
        check("rf_data",    rf_data_o,             e.data);
        check("last_grant", {31'd0, last_grant_o}, {31'd0, e.lg});
      end
    end
  end

  initial begin
    bit drained;
    // Requests pending during reset must be discarded.
    rst_n_i = 1'b0;
    wb0_valid_i = 1'b1; wb0_addr_i = 5'd9;  wb0_data_i = 32'h1234_5678;
    wb1_valid_i = 1'b1; wb1_addr_i = 5'd10; wb1_data_i = 32'h8765_4321;
    flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset rf_we",      {31'd0, rf_we_o},      32'd0);
    check("reset rf_addr",    {27'd0, rf_addr_o},    32'd0);
    check("reset rf_data",    rf_data_o,             32'd0);
    check("reset last_grant", {31'd0, last_grant_o}, 32'd1);
    rst_n_i = 1'b1;

    // Single ALU request.
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    idle();
    // Sustained tie.
    for (int i = 0; i < 5; i++)
      drive(1, 5'd3, 32'hA000_0000 + i, 1, 5'd4, 32'hB000_0000 + i, 0);
    idle();
    // Write to x0 is accepted but dropped.
    drive(0, 0, 0, 1, 0, 32'h1, 0);
    idle();
    // Same-address tie after the ALU won last.
    drive(1, 5'd2, 32'h55, 0, 0, 0, 0);
    drive(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0);
    drive(1, 5'd7, 32'h11, 0, 0, 0, 0);
    idle();
    // Flush during a tie.
    drive(1, 5'd8, 32'h88, 1, 5'd9, 32'h99, 1);
    idle();

    // Random traffic, biased toward small addresses for x0 and same-address ties.
    for (int i = 0; i < 400; i++) begin
      bit [4:0] a0, a1;
      a0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
      drive($urandom_range(0, 9) < 7, a0, $urandom,
            $urandom_range(0, 9) < 7, a1, $urandom,
            $urandom_range(0, 9) == 0);
    end
    drive(1, 5'd17, 32'hCAFE_0001, 0, 0, 0, 0);
    idle();
    idle();

    drained = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (wr_q.size() == 0 && rdy_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL drain: queues still hold %0d/%0d entries, required 0", wr_q.size(), rdy_q.size());
    end

    // Mid-cycle asynchronous reset clears outputs immediately.
    wb0_valid_i = 1'b1; wb1_valid_i = 1'b1;
    #3 rst_n_i = 1'b0;
    #1;
    check("async rf_we",      {31'd0, rf_we_o},      32'd0);
    check("async rf_addr",    {27'd0, rf_addr_o},    32'd0);
    check("async rf_data",    rf_data_o,             32'd0);
    check("async last_grant", {31'd0, last_grant_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have clk_i, input, 1, rising-edge clock.
REQ-002 SHALL have rst_n_i, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have wb0_valid_i / wb0_addr_i / wb0_data_i, input, 1/5/32, ALU writeback request.
REQ-004 SHALL have wb0_ready_o, output, 1, ALU request accepted this cycle.
REQ-005 SHALL have wb1_valid_i / wb1_addr_i / wb1_data_i, input, 1/5/32, load-unit writeback request.
REQ-006 SHALL have wb1_ready_o, output, 1, load request accepted this cycle.
REQ-007 SHALL have flush_i, input, 1, synchronous pipeline flush.
REQ-008 SHALL have rf_we_o / rf_addr_o / rf_data_o, output, 1/5/32, register-file write port (write enable, destination, data).
REQ-009 SHALL have last_grant_o, output, 1, requester granted most recently (0 = ALU, 1 = load).

Function
REQ-010 SHALL accept at most one request per cycle; wbN accepted iff wbN_valid_i and wbN_ready_o in the same cycle.
REQ-011 SHALL compute wbN_ready_o combinationally from valids and the pointer; wbN_ready_o = 0 when flush_i = 1.
REQ-012 SHALL arbitrate round-robin: with both valid, grant the requester not equal to last_grant_o; with one valid, grant it.
REQ-013 SHALL update last_grant_o to the granted id on every accept; unchanged when nothing is accepted.
REQ-014 SHALL register the accepted request: rf_we_o/rf_addr_o/rf_data_o valid exactly 1 cycle after accept, for one cycle only.
REQ-015 SHALL drive rf_we_o = 0 on the cycle after an accepted request with addr 0 (ready still asserted, write dropped).
REQ-016 SHALL drive rf_we_o = 0, and hold rf_addr_o/rf_data_o at their previous values, in cycles following no accept.
REQ-017 SHALL, when flush_i = 1, accept nothing and force rf_we_o = 0 next cycle; a write already on rf_*_o in the flush cycle completes.
REQ-018 SHALL, when both requesters target the same address, write the granted one first and the other no earlier than the next cycle.
REQ-019 SHALL sustain one write per cycle under continuous requests, with no bubble.

Reset
REQ-020 SHALL on rst_n_i = 0 immediately clear rf_we_o = 0, rf_addr_o = 0, rf_data_o = 0, last_grant_o = 1 (ALU wins the first tie), and the starvation counter = 0.
REQ-021 SHALL discard any request pending during reset; no write issues in the first cycle after deassertion.

Configuration
REQ-022 SHALL compile fixed-priority mode when REGFILE_WB_FIXED_PRIO_EN is defined: on a tie the load requester wins.
REQ-023 SHALL in that mode keep a 2-bit starvation counter that increments when ALU is valid and not granted, and clears when ALU is granted or not valid.
REQ-024 SHALL in that mode grant ALU on a tie when the counter equals 3.
REQ-025 SHALL use REQ-012 round-robin and contain no counter when the macro is undefined.

Structure
REQ-026 SHALL take XLEN = 32, REG_ADDR_W = 5, and requester ids REQ_ALU = 0 and REQ_LOAD = 1 from shared package regfile_pkg.
REQ-027 SHALL isolate grant logic (two valids, pointer, optional counter in, grant vector out) in sub-module wb_arb2.

Verification
REQ-028 SHALL cover a single request: wb0 valid, addr 5, data 0xDEADBEEF -> ready same cycle; next cycle rf_we_o = 1, addr 5, data 0xDEADBEEF.
REQ-029 SHALL cover a sustained tie over 4 cycles (round-robin build): grants ALU, load, ALU, load; rf_we_o = 1 every cycle from cycle 1.
REQ-030 SHALL cover writes to x0: wb1 valid, addr 0, data 0x1 -> wb1_ready_o = 1; next cycle rf_we_o = 0.
REQ-031 SHALL cover a same-address tie: addr 7, wb0 data 0x11, wb1 data 0x22, last_grant_o = 0 -> write 0x22 at cycle 1, then 0x11 at cycle 2.
REQ-032 SHALL cover flush during a tie: flush_i = 1 -> both readies 0; next cycle rf_we_o = 0; state unchanged.
REQ-033 SHALL cover fixed-priority starvation: both valid for 5 cycles -> grants load, load, load, ALU, load.
